// File: rtl/t09_tone_pkg.sv
// t09_tone_pkg: shared FSM state type, default snake-game tone tables and table lookup.
package t09_tone_pkg;
  typedef enum logic {IDLE, PLAY} state_t;
  localparam int DEF_NUM_EV = 4;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_DUR_W = 24;
  // Entries from index 3 down to 0: game over, food spawn, bad collision, good collision.
  localparam logic [31:0] DEF_HALF_PERIOD = {8'd200, 8'd60, 8'd156, 8'd89};
  localparam logic [95:0] DEF_DURATION = {24'd6000000, 24'd1500000, 24'd10000000, 24'd3000000};
  function automatic logic [31:0] tbl_entry(input logic [1023:0] tbl, input int w, input int i);
    logic [1023:0] s;
    s = tbl >> (i * w);
    return (w >= 32) ? s[31:0] : (s[31:0] & ((32'd1 << w) - 32'd1));
  endfunction
endpackage

// File: rtl/t09_tone_divider.sv
// t09_tone_divider: half-period counter producing the tick pulse and the square wave.
module t09_tone_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] half_period,
  output logic             tick,
  output logic             wave
);
  logic [DIV_W-1:0] div_cnt;
  logic wrap;
  assign wrap = div_cnt == half_period;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      div_cnt <= '0;
      tick <= 1'b0;
      wave <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      tick <= 1'b0;
      wave <= 1'b0;
    end else if (run) begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      tick <= wrap;
      wave <= wave ^ wrap;
    end
endmodule

// File: rtl/t09_tone_gen.sv
// t09_tone_gen: priority-arbitrated multi-event buzzer with per-event pitch and duration.
module t09_tone_gen
  import t09_tone_pkg::*;
#(
  parameter int                          NUM_EV      = DEF_NUM_EV,
  parameter int                          DIV_W       = DEF_DIV_W,
  parameter int                          DUR_W       = DEF_DUR_W,
  parameter logic [NUM_EV*DIV_W-1:0]     HALF_PERIOD = DEF_HALF_PERIOD,
  parameter logic [NUM_EV*DUR_W-1:0]     DURATION    = DEF_DURATION,
  parameter int                          EV_W        = (NUM_EV > 1) ? $clog2(NUM_EV) : 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  input  logic [NUM_EV-1:0] ev_req,
  output logic              tick,
  output logic              wave,
  output logic              busy,
  output logic [EV_W-1:0]   active_ev
);
  state_t state;
  logic [DUR_W-1:0] remain;
  logic [DIV_W-1:0] hp_tab [NUM_EV];
  logic [DUR_W-1:0] dur_tab [NUM_EV];
  logic [EV_W-1:0] sel;
  logic sel_vld, preempt, done, clear, run;
  for (genvar i = 0; i < NUM_EV; i++) begin : g_tab
    assign hp_tab[i] = DIV_W'(tbl_entry(1024'(HALF_PERIOD), DIV_W, i));
    assign dur_tab[i] = DUR_W'(tbl_entry(1024'(DURATION), DUR_W, i));
  end
  // Zero-duration entries never win, so remain is never loaded with 0.
  always_comb begin
    sel = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_EV; k++)
      if (ev_req[k] && dur_tab[k] != '0) begin
        sel = EV_W'(k);
        sel_vld = 1'b1;
      end
  end
  assign preempt = en && sel_vld && (state == IDLE || sel > active_ev);
  assign done = state == PLAY && remain == DUR_W'(1);
  assign clear = !en || state == IDLE || preempt || done;
  assign run = state == PLAY;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      busy <= 1'b0;
      active_ev <= '0;
      remain <= '0;
    end else if (preempt) begin
      state <= PLAY;
      busy <= 1'b1;
      active_ev <= sel;
      remain <= dur_tab[sel];
    end else if (!en || done || state == IDLE) begin
      state <= IDLE;
      busy <= 1'b0;
      active_ev <= '0;
      remain <= '0;
    end else begin
      remain <= remain - 1'b1;
    end
  t09_tone_divider #(.DIV_W(DIV_W)) u_div (
    .clk(clk),
    .nRst(nRst),
    .clear(clear),
    .run(run),
    .half_period(hp_tab[active_ev]),
    .tick(tick),
    .wave(wave)
  );
endmodule

// File: tb/tb_t09_tone_gen.sv
// tb_t09_tone_gen: scoreboard bench; stimulus pushes expected outputs, monitor pops on each falling edge.
module tb_t09_tone_gen;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic en = 1'b0;
  logic [3:0] ev_req = 4'b0;
  logic tick, wave, busy;
  logic [1:0] active_ev;
  int hp_t [4] = '{1, 3, 2, 5};
  int dur_t [4] = '{10, 20, 12, 30};
  int checks = 0, passed = 0, cyc = 0;
  int m_play = 0, m_e = 0, m_c = 0;
  logic [4:0] exp_q [$];

  t09_tone_gen #(
    .NUM_EV(4), .DIV_W(8), .DUR_W(24),
    .HALF_PERIOD({8'd5, 8'd2, 8'd3, 8'd1}),
    .DURATION({24'd30, 24'd12, 24'd20, 24'd10})
  ) dut (
    .clk(clk), .nRst(nRst), .en(en), .ev_req(ev_req),
    .tick(tick), .wave(wave), .busy(busy), .active_ev(active_ev)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] expected();
    logic t, w;
    t = m_play != 0 && m_c > 0 && (m_c % (hp_t[m_e] + 1)) == 0;
    w = m_play != 0 && ((m_c / (hp_t[m_e] + 1)) % 2) == 1;
    return {m_play != 0, (m_play != 0) ? 2'(m_e) : 2'd0, t, w};
  endfunction

  task automatic model_edge();
    int s = -1;
    for (int i = 0; i < 4; i++) if (ev_req[i] && dur_t[i] != 0) s = i;
    if (!nRst || !en) m_play = 0;
    else if (s >= 0 && (m_play == 0 || s > m_e)) begin
      m_play = 1; m_e = s; m_c = 0;
    end else if (m_play != 0) begin
      m_c++;
      if (m_c == dur_t[m_e]) m_play = 0;
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r);
    @(negedge clk);
    en = e;
    ev_req = r;
    @(posedge clk);
    model_edge();
    exp_q.push_back(expected());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0);
  endtask

  task automatic check_now(input string name, input logic [4:0] want);
    checks++;
    if ({busy, active_ev, tick, wave} === want) passed++;
    else $display("FAIL %s: got busy/ev/tick/wave=%b required %b", name, {busy, active_ev, tick, wave}, want);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) check_now($sformatf("cycle%0d", cyc), exp_q.pop_front());
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_now("reset", 5'b0);
    @(negedge clk);
    nRst = 1'b1;
    idle(50);
    step(1'b1, 4'b0010);
    idle(25);
    step(1'b1, 4'b0101);
    idle(15);
    step(1'b1, 4'b0001);
    idle(3);
    step(1'b1, 4'b1000);
    idle(10);
    step(1'b1, 4'b0010);
    idle(25);
    step(1'b1, 4'b0010);
    idle(5);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1000);
    idle(3);
    step(1'b1, 4'b0100);
    idle(15);
    step(1'b1, 4'b0010);
    idle(6);
    @(negedge clk);
    #2 nRst = 1'b0;
    #1 check_now("async_reset", 5'b0);
    m_play = 0;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    nRst = 1'b1;
    idle(10);
    step(1'b1, 4'b0001);
    idle(12);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
